// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the radix-2 FFT butterfly sequencer.
//   FFT_L / FFT_N  : default transform size (log2 points / points)
//   BFU_LAT_DEF    : default read-issue to butterfly-output latency
//   fft_adr_t      : sample RAM address at the default size
//   tw_adr_t       : twiddle ROM address at the default size
//   fft_ctrl_state_t : sequencer states
//   rotl()         : rotate-left of the low w bits of a vector
package fft_pkg;

  localparam int FFT_L       = 5;
  localparam int FFT_N       = 2 ** FFT_L;
  localparam int BFU_LAT_DEF = 2;
  localparam int ROT_W       = 16;

  typedef logic [FFT_L-1:0] fft_adr_t;
  typedef logic [FFT_L-2:0] tw_adr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fft_ctrl_state_t;

  // Rotates the low w bits of x left by n (n < w). The value is widened
  // so the bits pushed past position w can be folded back to the bottom.
  function automatic logic [ROT_W-1:0] rotl(input logic [ROT_W-1:0] x,
                                            input int unsigned w,
                                            input int unsigned n);
    logic [2*ROT_W-1:0] dbl;
    logic [ROT_W-1:0]   mask;
    mask = (ROT_W'(1) << w) - ROT_W'(1);
    dbl  = {ROT_W'(0), x & mask} << n;
    return (dbl[ROT_W-1:0] | ROT_W'(dbl >> w)) & mask;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// fft_agu: combinational butterfly address and twiddle address generator.
//   i_i      : butterfly index within the stage (0 .. N/2-1)
//   i_s      : stage index (0 .. L-1)
//   o_adr_a  : input A address, rotl(2i, s)
//   o_adr_b  : input B address, rotl(2i+1, s)
//   o_tw_adr : twiddle ROM address, i with its low (L-1-s) bits cleared
module fft_agu
  import fft_pkg::*;
#(
  parameter int L = FFT_L
) (
  input  logic [L-2:0]         i_i,
  input  logic [$clog2(L)-1:0] i_s,
  output logic [L-1:0]         o_adr_a,
  output logic [L-1:0]         o_adr_b,
  output logic [L-2:0]         o_tw_adr
);

  // The pair addresses are the butterfly index with a 0/1 appended as LSB,
  // rotated by the stage number so that stage s pairs points 2**s apart.
  // The twiddle mask keeps only the top s bits of i, which is the twiddle
  // exponent scaled to the full N/2-entry ROM.
  always_comb begin
    o_adr_a  = L'(rotl(ROT_W'({i_i, 1'b0}), L, 32'(i_s)));
    o_adr_b  = L'(rotl(ROT_W'({i_i, 1'b1}), L, 32'(i_s)));
    o_tw_adr = i_i & ({(L-1){1'b1}} << ((L - 1) - int'(i_s)));
  end

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for the in-place radix-2 FFT butterfly datapath.
// Issues one butterfly per clock over all L stages, delays the write side
// by BFU_LAT cycles and pulses o_done once the last result is written.
//   i_clk / i_reset     : clock, asynchronous active-high reset
//   i_stall             : (FFT_CTRL_STALL_EN only) freezes the sequencer
//   i_start             : begins a transform when idle
//   o_busy / o_done     : transform in progress / completion pulse
//   o_rd_adr_a/b        : butterfly read addresses
//   o_wr_adr_a/b, o_we  : butterfly write addresses and enable
//   o_twiddle_adr       : twiddle ROM address
//   o_rd_bank / o_stage : bank read this stage, current stage
// Optional feature macro: FFT_CTRL_STALL_EN adds the i_stall input.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int L       = FFT_L,
  parameter int BFU_LAT = BFU_LAT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
`ifdef FFT_CTRL_STALL_EN
  input  logic                 i_stall,
`endif
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [L-1:0]         o_rd_adr_a,
  output logic [L-1:0]         o_rd_adr_b,
  output logic [L-1:0]         o_wr_adr_a,
  output logic [L-1:0]         o_wr_adr_b,
  output logic                 o_we,
  output logic [L-2:0]         o_twiddle_adr,
  output logic                 o_rd_bank,
  output logic [$clog2(L)-1:0] o_stage
);

  localparam int              SW     = $clog2(L);
  localparam logic [L-2:0]    I_LAST = '1;
  localparam logic [SW-1:0]   S_LAST = SW'(L - 1);
  localparam logic [2:0]      D_LAST = 3'(BFU_LAT - 1);

  fft_ctrl_state_t r_state, w_state_nxt;
  logic [L-2:0]    r_i, w_i_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic            r_bank, w_bank_nxt;
  logic [2:0]      r_dcnt, w_dcnt_nxt;
  logic            w_accept;
  logic            w_stall;

  logic [L-1:0]    w_adr_a, w_adr_b;
  logic [L-2:0]    w_tw;

  logic            r_iss, r_busy, r_done, r_bank_out;
  logic [L-1:0]    r_rd_a, r_rd_b;
  logic [L-2:0]    r_tw;
  logic [SW-1:0]   r_stage;
  logic [BFU_LAT-1:0] r_vpipe;
  logic [L-1:0]    r_apipe_a [BFU_LAT];
  logic [L-1:0]    r_apipe_b [BFU_LAT];

`ifdef FFT_CTRL_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  fft_agu #(.L(L)) u_agu (
    .i_i     (r_i),
    .i_s     (r_s),
    .o_adr_a (w_adr_a),
    .o_adr_b (w_adr_b),
    .o_tw_adr(w_tw)
  );

  // Next-state logic. A start is refused while the done pulse is still on
  // the output, so a start held through completion cannot retrigger.
  // DONE returns stage and bank to zero so every transform reads bank 0
  // at stage 0.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_s_nxt     = r_s;
    w_bank_nxt  = r_bank;
    w_dcnt_nxt  = r_dcnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !r_done) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
          w_i_nxt     = '0;
          w_s_nxt     = '0;
          w_bank_nxt  = 1'b0;
        end
      end
      ISSUE: begin
        w_i_nxt = r_i + 1'b1;
        if (r_i == I_LAST) begin
          w_state_nxt = DRAIN;
          w_dcnt_nxt  = '0;
        end
      end
      DRAIN: begin
        w_dcnt_nxt = r_dcnt + 3'd1;
        if (r_dcnt == D_LAST) begin
          if (r_s != S_LAST) begin
            w_state_nxt = ISSUE;
            w_s_nxt     = r_s + 1'b1;
            w_bank_nxt  = ~r_bank;
            w_i_nxt     = '0;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_s_nxt     = '0;
        w_bank_nxt  = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequencer state register; a stall simply withholds the clock enable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_s     <= '0;
      r_bank  <= 1'b0;
      r_dcnt  <= '0;
    end else if (!w_stall) begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_s     <= w_s_nxt;
      r_bank  <= w_bank_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // Registered outputs trail the sequencer state by one cycle, so the
  // issue flag and its addresses appear together. The write side is the
  // issue flag and read addresses pushed through a BFU_LAT-deep shift
  // register, matching the butterfly's read-to-result latency.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_iss      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bank_out <= 1'b0;
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_tw       <= '0;
      r_stage    <= '0;
      r_vpipe    <= '0;
      for (int k = 0; k < BFU_LAT; k++) begin
        r_apipe_a[k] <= '0;
        r_apipe_b[k] <= '0;
      end
    end else if (!w_stall) begin
      r_iss      <= (r_state == ISSUE);
      r_done     <= (r_state == DONE);
      r_bank_out <= r_bank;
      r_rd_a     <= w_adr_a;
      r_rd_b     <= w_adr_b;
      r_tw       <= w_tw;
      r_stage    <= r_s;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
      r_vpipe[0]   <= r_iss;
      r_apipe_a[0] <= r_rd_a;
      r_apipe_b[0] <= r_rd_b;
      for (int k = 1; k < BFU_LAT; k++) begin
        r_vpipe[k]   <= r_vpipe[k-1];
        r_apipe_a[k] <= r_apipe_a[k-1];
        r_apipe_b[k] <= r_apipe_b[k-1];
      end
    end
  end

  // The write enable is the only output gated directly by stall so that
  // a frozen pipeline never writes the same result twice.
  always_comb begin
    o_we = r_vpipe[BFU_LAT-1] & ~w_stall;
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_rd_adr_a    = r_rd_a;
  assign o_rd_adr_b    = r_rd_b;
  assign o_wr_adr_a    = r_apipe_a[BFU_LAT-1];
  assign o_wr_adr_b    = r_apipe_b[BFU_LAT-1];
  assign o_twiddle_adr = r_tw;
  assign o_rd_bank     = r_bank_out;
  assign o_stage       = r_stage;

endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: self-checking bench for fft_ctrl at L=3, BFU_LAT=2.
// Expected behaviour comes from a cycle-indexed reference model: the
// butterfly schedule, address rotation and twiddle rule are computed with
// integer arithmetic for each cycle counted from the start-accept edge.
// Optional feature macro: FFT_CTRL_STALL_EN enables the stall scenario.
module tb_fft_ctrl;

  localparam int TL   = 3;
  localparam int TLAT = 2;
  localparam int N    = 2 ** TL;
  localparam int H    = N / 2;
  localparam int PER  = TL * (H + TLAT);
  localparam int T    = PER + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic          busy, done, we, rd_bank;
  logic [TL-1:0] rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
  logic [TL-2:0] twiddle_adr;
  logic [1:0]    stage;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_ctrl #(.L(TL), .BFU_LAT(TLAT)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
`ifdef FFT_CTRL_STALL_EN
    .i_stall      (stall),
`endif
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_adr_a   (rd_adr_a),
    .o_rd_adr_b   (rd_adr_b),
    .o_wr_adr_a   (wr_adr_a),
    .o_wr_adr_b   (wr_adr_b),
    .o_we         (we),
    .o_twiddle_adr(twiddle_adr),
    .o_rd_bank    (rd_bank),
    .o_stage      (stage)
  );

  // Rotate an L-bit address left by n places.
  function automatic int expRotl(int x, int n);
    return ((x << n) | (x >> (TL - n))) % N;
  endfunction

  // Twiddle exponent: butterfly index with its low (L-1-s) bits dropped.
  function automatic int expTw(int i, int s);
    return (i >> (TL - 1 - s)) << (TL - 1 - s);
  endfunction

  // Butterfly issued in model cycle m (if any): stage s, index i.
  function automatic bit issueAt(int m, output int s, output int i);
    int idx;
    s = 0;
    i = 0;
    idx = m - 1;
    if (m < 1 || idx >= PER) return 1'b0;
    s = idx / (H + TLAT);
    i = idx % (H + TLAT);
    return (i < H);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for model cycle m.
  task automatic checkCycle(int m, bit stalled);
    int s, i, ws, wi;
    bit iss, wv;
    iss = issueAt(m, s, i);
    wv  = issueAt(m - TLAT, ws, wi);
    checkOutput("busy", 32'(busy), (m <= T) ? 1 : 0);
    checkOutput("done", 32'(done), (m == T) ? 1 : 0);
    checkOutput("we", 32'(we), (wv && !stalled) ? 1 : 0);
    if (wv) begin
      checkOutput("wr_adr_a", 32'(wr_adr_a), expRotl(2 * wi, ws));
      checkOutput("wr_adr_b", 32'(wr_adr_b), expRotl(2 * wi + 1, ws));
    end
    if (iss) begin
      checkOutput("rd_adr_a", 32'(rd_adr_a), expRotl(2 * i, s));
      checkOutput("rd_adr_b", 32'(rd_adr_b), expRotl(2 * i + 1, s));
      checkOutput("twiddle_adr", 32'(twiddle_adr), expTw(i, s));
      checkOutput("rd_bank", 32'(rd_bank), s % 2);
      checkOutput("stage", 32'(stage), s);
    end
  endtask

  task automatic checkZero(string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_we"}, 32'(we), 0);
    checkOutput({tag, "_rd_a"}, 32'(rd_adr_a), 0);
    checkOutput({tag, "_rd_b"}, 32'(rd_adr_b), 0);
    checkOutput({tag, "_wr_a"}, 32'(wr_adr_a), 0);
    checkOutput({tag, "_wr_b"}, 32'(wr_adr_b), 0);
    checkOutput({tag, "_tw"}, 32'(twiddle_adr), 0);
    checkOutput({tag, "_bank"}, 32'(rd_bank), 0);
    checkOutput({tag, "_stage"}, 32'(stage), 0);
  endtask

  task automatic idleCycles(int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("idle_we", 32'(we), 0);
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_done", 32'(done), 0);
    end
  endtask

  // One transform, entered and left at a falling edge. Optional start
  // hold, a stall window beginning at model cycle stallAt, or an
  // asynchronous reset at loop cycle abortAt.
  task automatic applyStimulus(bit holdStart, int stallAt, int stallLen, int abortAt);
    int m;
    int stallCnt;
    bit stallUsed;
    m = 0;
    stallCnt = 0;
    stallUsed = 1'b0;
    start = 1'b1;
    @(negedge clk);
    if (!holdStart) start = 1'b0;
    for (int cyc = 0; cyc < T + 4 + stallLen; cyc++) begin
      if (cyc == abortAt) begin
        #2 reset = 1'b1;
        #1 checkZero("abort");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        idleCycles(3);
        return;
      end
      checkCycle(m, stall);
      if (holdStart && m >= T) start = 1'b0;
      if (stallCnt > 0) begin
        stallCnt--;
        if (stallCnt == 0) stall = 1'b0;
      end else if (m == stallAt && !stallUsed && stallLen > 0) begin
        stall = 1'b1;
        stallCnt = stallLen;
        stallUsed = 1'b1;
      end
      if (!stall) m++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    $display("[TB] reset state");
    checkZero("reset");
    reset = 1'b0;
    idleCycles(2);

    $display("[TB] basic transform");
    applyStimulus(1'b0, -1, 0, -1);
    idleCycles(2);

    $display("[TB] start held through done");
    applyStimulus(1'b1, -1, 0, -1);
    idleCycles(2);

    $display("[TB] reset during stage 1");
    applyStimulus(1'b0, -1, 0, int'($urandom_range(7, 10)));
    applyStimulus(1'b0, -1, 0, -1);

    $display("[TB] randomized back-to-back runs");
    for (int r = 0; r < 3; r++) begin
      idleCycles(int'($urandom_range(1, 4)));
      applyStimulus(1'($urandom_range(0, 1)), -1, 0, -1);
    end

`ifdef FFT_CTRL_STALL_EN
    $display("[TB] stall during stage 0");
    idleCycles(1);
    applyStimulus(1'b0, 3, 3, -1);
    idleCycles(1);
    applyStimulus(1'b0, int'($urandom_range(1, T)), int'($urandom_range(1, 4)), -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
